// File: rtl/dlf_pi_pkg.sv
// Shared types, format constants and saturation helper for the PI loop filter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
`timescale 1ns/1ps
package dlf_pkg;

    // Loop state: ACQ uses wide gains, TRACK uses narrow gains.
    typedef enum logic {
        ACQ   = 1'b0,
        TRACK = 1'b1
    } dlf_state_t;

    localparam int DLF_FRAC  = 6;   // fractional bits of the integrator
    localparam int DLF_OUT_W = 10;  // DCO code width
    localparam int DLF_INT_W = 16;  // integrator width (Q10.6, unsigned)
    localparam int DLF_SUM_W = 18;  // signed width of every intermediate sum

    // Clamp a signed sum into [0, hi]; hi is always non-negative.
    function automatic logic signed [DLF_SUM_W-1:0] dlf_sat(
        input logic signed [DLF_SUM_W-1:0] v,
        input logic signed [DLF_SUM_W-1:0] hi
    );
        if (v < 0)
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/dlf_pi_if.sv
// Loop-filter bus: enable and TDC error in, DCO code and lock flag out.
// Latency: n/a (wiring only).
// Backpressure: none; the loop consumes one error sample per enabled edge.
`timescale 1ns/1ps
interface dlf_pi_if;
    logic              en;
    logic signed [3:0] in;
    logic [9:0]        out;
    logic              locked;

    modport master (output en, in, input out, locked);
    modport slave  (input en, in, output out, locked);
endinterface

// File: rtl/dlf_pi_lock_fsm.sv
// Lock detector: ACQ/TRACK state, small/large error run counters, gain select.
// Latency: state, locked and gain_sel are registered; gains follow one edge later.
// Backpressure: none; en=0 freezes every register.
`timescale 1ns/1ps
module dlf_lock_fsm
    import dlf_pkg::*;
#(
    parameter int LOCK_CNT = 32
) (
    input  logic              clk_fb,
    input  logic              rstn,
    input  logic              en,
    input  logic signed [3:0] err,
    output dlf_state_t        gain_sel,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LOCK_CNT);

    dlf_state_t       state;
    logic [CNT_W-1:0] small_cnt;
    logic [CNT_W-1:0] small_nxt;
    logic             big_seen;
    logic             err_small;
    logic             err_big;

    // Classify the current error and work out the saturating small-run count.
    always_comb begin
        err_small = (err >= -4'sd1) && (err <= 4'sd1);
        err_big   = (err >= 4'sd6) || (err <= -4'sd6);
        small_nxt = '0;
        if (err_small)
            small_nxt = (small_cnt == CNT_FULL) ? CNT_FULL : small_cnt + 1'b1;
    end

    // Lock state machine; locked and gain_sel are registered copies of the state.
    always_ff @(posedge clk_fb) begin
        if (!rstn) begin
            state     <= ACQ;
            small_cnt <= '0;
            big_seen  <= 1'b0;
            locked    <= 1'b0;
            gain_sel  <= ACQ;
        end else if (en) begin
            unique case (state)
                ACQ: begin
                    big_seen  <= 1'b0;
                    small_cnt <= small_nxt;
                    // A full run of small errors already seen declares lock.
                    if (small_cnt == CNT_FULL) begin
                        state    <= TRACK;
                        locked   <= 1'b1;
                        gain_sel <= TRACK;
                    end
                end
                TRACK: begin
                    // Two large errors back to back drop back to acquisition.
                    if (err_big && big_seen) begin
                        state     <= ACQ;
                        locked    <= 1'b0;
                        gain_sel  <= ACQ;
                        big_seen  <= 1'b0;
                        small_cnt <= '0;
                    end else begin
                        big_seen  <= err_big;
                        small_cnt <= small_nxt;
                    end
                end
                default: begin
                    state    <= ACQ;
                    locked   <= 1'b0;
                    gain_sel <= ACQ;
                end
            endcase
        end
    end

endmodule

// File: rtl/dlf_pi.sv
// PI digital loop filter: TDC error -> Q10.6 integrator -> 10-bit DCO code (optional DSM via DLF_DSM_EN).
// Latency: one clk_fb edge from in to out.
// Backpressure: none; en=0 holds integrator, output, lock state and dither accumulator.
`timescale 1ns/1ps
module dlf_pi
    import dlf_pkg::*;
#(
    parameter int INIT_CODE    = 512,
    parameter int KP_SHIFT_ACQ = 0,
    parameter int KI_SHIFT_ACQ = 2,
    parameter int KP_SHIFT_TRK = 2,
    parameter int KI_SHIFT_TRK = 5,
    parameter int LOCK_CNT     = 32
) (
    input  logic     clk_fb,
    input  logic     rstn,
    dlf_pi_if.slave  bus
);

    localparam logic [DLF_INT_W-1:0]        INTEG_RST = DLF_INT_W'(INIT_CODE * (1 << DLF_FRAC));
    localparam logic [DLF_OUT_W-1:0]        OUT_RST   = DLF_OUT_W'(INIT_CODE);
    localparam logic signed [DLF_SUM_W-1:0] INTEG_MAX = DLF_SUM_W'((1 << DLF_INT_W) - 1);
    localparam logic signed [DLF_SUM_W-1:0] OUT_MAX   = DLF_SUM_W'((1 << DLF_OUT_W) - 1);

    dlf_state_t                    gain_sel;
    logic                          locked_q;
    logic [2:0]                    kp_sh;
    logic [2:0]                    ki_sh;
    logic [DLF_INT_W-1:0]          integ;
    logic [DLF_INT_W-1:0]          integ_new;
    logic [DLF_OUT_W-1:0]          out_q;
    logic [DLF_OUT_W-1:0]          out_new;
    logic signed [DLF_SUM_W-1:0]   err_scaled;
    logic signed [DLF_SUM_W-1:0]   p_term;
    logic signed [DLF_SUM_W-1:0]   i_term;
    logic signed [DLF_SUM_W-1:0]   integ_sum;
    logic signed [DLF_SUM_W-1:0]   fsum;
    logic signed [DLF_SUM_W-1:0]   out_int;
`ifdef DLF_DSM_EN
    logic [DLF_FRAC-1:0]           dsm_acc;
    logic [DLF_FRAC:0]             dsm_sum;
`endif

    dlf_lock_fsm #(
        .LOCK_CNT (LOCK_CNT)
    ) u_lock (
        .clk_fb   (clk_fb),
        .rstn     (rstn),
        .en       (bus.en),
        .err      (bus.in),
        .gain_sel (gain_sel),
        .locked   (locked_q)
    );

    assign bus.out    = out_q;
    assign bus.locked = locked_q;

    // Datapath: gains come from the registered state, so a transition edge still uses the old ones.
    always_comb begin
        kp_sh      = (gain_sel == TRACK) ? 3'(KP_SHIFT_TRK) : 3'(KP_SHIFT_ACQ);
        ki_sh      = (gain_sel == TRACK) ? 3'(KI_SHIFT_TRK) : 3'(KI_SHIFT_ACQ);
        err_scaled = {{(DLF_SUM_W-4-DLF_FRAC){bus.in[3]}}, bus.in, {DLF_FRAC{1'b0}}};
        p_term     = err_scaled >>> kp_sh;
        i_term     = err_scaled >>> ki_sh;
        integ_sum  = $signed({2'b00, integ}) + i_term;
        integ_new  = DLF_INT_W'(dlf_sat(integ_sum, INTEG_MAX));
        fsum       = $signed({2'b00, integ_new}) + p_term;
`ifdef DLF_DSM_EN
        // First-order dither: fractional bits accumulate, carry bumps the integer code.
        dsm_sum    = {1'b0, dsm_acc} + {1'b0, fsum[DLF_FRAC-1:0]};
        out_int    = (fsum >>> DLF_FRAC) + $signed({{(DLF_SUM_W-1){1'b0}}, dsm_sum[DLF_FRAC]});
`else
        out_int    = fsum >>> DLF_FRAC;
`endif
        out_new    = DLF_OUT_W'(dlf_sat(out_int, OUT_MAX));
    end

    // Integrator and output code registers.
    always_ff @(posedge clk_fb) begin
        if (!rstn) begin
            integ <= INTEG_RST;
            out_q <= OUT_RST;
        end else if (bus.en) begin
            integ <= integ_new;
            out_q <= out_new;
        end
    end

`ifdef DLF_DSM_EN
    // Dither accumulator keeps only the fractional residue.
    always_ff @(posedge clk_fb) begin
        if (!rstn)
            dsm_acc <= '0;
        else if (bus.en)
            dsm_acc <= dsm_sum[DLF_FRAC-1:0];
    end
`endif

endmodule

// File: tb/tb_dlf_pi.sv
// Self-checking bench for dlf_pi: directed loop scenarios plus randomized run vs. arithmetic model.
// Latency: expects out/locked one clk_fb edge after inputs.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_dlf_pi;

    localparam int INIT = 512;
    localparam int LCNT = 32;

    logic clk_fb = 1'b0;
    logic rstn;
    dlf_pi_if bus ();

    dlf_pi #(
        .INIT_CODE    (INIT),
        .KP_SHIFT_ACQ (0),
        .KI_SHIFT_ACQ (2),
        .KP_SHIFT_TRK (2),
        .KI_SHIFT_TRK (5),
        .LOCK_CNT     (LCNT)
    ) dut (
        .clk_fb (clk_fb),
        .rstn   (rstn),
        .bus    (bus)
    );

    always #5 clk_fb = ~clk_fb;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state, plain integers.
    int m_integ, m_out, m_acc, m_small, m_big;
    bit m_trk;
    int dsm_sum;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int floordiv(input int v, input int d);
        if (v >= 0)
            return v / d;
        else
            return -((-v + d - 1) / d);
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model(input bit r, input bit e, input int x);
        int ki, kp, f, c, ax;
        if (!r) begin
            m_integ = INIT * 64;
            m_out   = INIT;
            m_trk   = 1'b0;
            m_small = 0;
            m_big   = 0;
            m_acc   = 0;
        end else if (e) begin
            ki = m_trk ? 5 : 2;
            kp = m_trk ? 2 : 0;
            m_integ = clamp(m_integ + floordiv(x * 64, 1 << ki), 0, 65535);
            f = m_integ + floordiv(x * 64, 1 << kp);
            c = 0;
`ifdef DLF_DSM_EN
            m_acc = m_acc + (f - floordiv(f, 64) * 64);
            if (m_acc >= 64) begin
                c = 1;
                m_acc = m_acc - 64;
            end
`endif
            m_out = clamp(floordiv(f, 64) + c, 0, 1023);
            ax = (x < 0) ? -x : x;
            if (!m_trk) begin
                if (m_small >= LCNT) m_trk = 1'b1;
                m_small = (ax <= 1) ? ((m_small + 1 > LCNT) ? LCNT : m_small + 1) : 0;
                m_big = 0;
            end else begin
                m_big   = (ax >= 6) ? m_big + 1 : 0;
                m_small = (ax <= 1) ? ((m_small + 1 > LCNT) ? LCNT : m_small + 1) : 0;
                if (m_big >= 2) begin
                    m_trk   = 1'b0;
                    m_big   = 0;
                    m_small = 0;
                end
            end
        end
    endtask

    // One clock edge: drive, advance model, sample 1 ns after the edge.
    task automatic step(input bit r, input bit e, input int x);
        rstn   = r;
        bus.en = e;
        bus.in = 4'(x);
        @(posedge clk_fb);
        model(r, e, x);
        #1;
        chk("out",    int'(bus.out),    m_out);
        chk("locked", int'(bus.locked), int'(m_trk));
        chk("integ",  int'(dut.integ),  m_integ);
    endtask

    initial begin
        int phase, sel, x;
        bit r, e;
        rstn   = 1'b0;
        bus.en = 1'b0;
        bus.in = '0;
        @(negedge clk_fb);

        // Reset state, with en low.
        step(0, 0, 0);
        chk("rst_out", int'(bus.out), 512);
        chk("rst_lock", int'(bus.locked), 0);

        // Constant +1 in acquisition.
        step(1, 1, 1);
`ifndef DLF_DSM_EN
        chk("acq_e1", int'(bus.out), 513);
`endif
        step(1, 1, 1);
        step(1, 1, 1);
        step(1, 1, 1);
`ifndef DLF_DSM_EN
        chk("acq_e4", int'(bus.out), 514);
`endif
        chk("acq_nolock", int'(bus.locked), 0);

        // Lock after 32 small errors, declared on edge 33; then tracking gains.
        step(0, 1, 0);
        for (int i = 0; i < 32; i++) step(1, 1, 0);
        chk("lock_e32", int'(bus.locked), 0);
        step(1, 1, 0);
        chk("lock_e33", int'(bus.locked), 1);
        chk("lock_out", int'(bus.out), 512);
        step(1, 1, 1);
        chk("trk_iterm", int'(dut.integ), 32768 + 2);

        // One large error is tolerated; two in a row drop lock.
        step(1, 1, 7);
        step(1, 1, 0);
        chk("single_big", int'(bus.locked), 1);
        step(1, 1, 7);
        chk("big_1", int'(bus.locked), 1);
        step(1, 1, 7);
        chk("big_2", int'(bus.locked), 0);

        // Upper and lower saturation.
        step(0, 1, 0);
        for (int i = 0; i < 320; i++) step(1, 1, 7);
        chk("sat_hi_out", int'(bus.out), 1023);
        chk("sat_hi_int", int'(dut.integ), 65535);
        for (int i = 0; i < 540; i++) step(1, 1, -8);
        chk("sat_lo_out", int'(bus.out), 0);
        chk("sat_lo_int", int'(dut.integ), 0);

        // en=0 freezes everything including the small-error run.
        step(0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 7);
        chk("hold_out", int'(bus.out), 512);
        for (int i = 0; i < 12; i++) step(1, 1, 0);
        chk("hold_nolock", int'(bus.locked), 0);
        step(1, 1, 0);
        chk("hold_lock", int'(bus.locked), 1);

        // Reset mid-run wins over en=0.
        step(1, 1, 7);
        step(0, 0, 7);
        chk("midrst_out", int'(bus.out), 512);
        chk("midrst_lock", int'(bus.locked), 0);

`ifdef DLF_DSM_EN
        // Preload integ to 512.5 in ACQ, lock, then average the dithered code.
        step(0, 1, 0);
        step(1, 1, 1);
        step(1, 1, 1);
        for (int i = 0; i < 31; i++) step(1, 1, 0);
        chk("dsm_lock", int'(bus.locked), 1);
        dsm_sum = 0;
        for (int i = 0; i < 64; i++) begin
            step(1, 1, 0);
            dsm_sum += int'(bus.out);
        end
        chk("dsm_mean", dsm_sum, 64 * 512 + 32);
`endif

        // Randomized run: phases bias toward locking, mixed, and unlocking.
        step(0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            phase = (i / 150) % 3;
            sel   = int'($urandom_range(0, 99));
            if (phase == 0)
                x = (sel < 98) ? int'($urandom_range(0, 2)) - 1 : int'($urandom_range(0, 15)) - 8;
            else if (phase == 1)
                x = int'($urandom_range(0, 15)) - 8;
            else
                x = (sel < 60) ? ((sel % 2 == 0) ? 7 - int'($urandom_range(0, 1)) : -6 - int'($urandom_range(0, 2)))
                               : int'($urandom_range(0, 2)) - 1;
            r = !(phase == 1 && $urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            step(r, e, x);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dlf_pi.md
DLF_PI -- requirements
Module: dlf_pi

Interface
REQ-001 Parameter INIT_CODE, 512: integrator and output value after reset (0..1023).
REQ-002 Parameter KP_SHIFT_ACQ, 0; KI_SHIFT_ACQ, 2: right-shifts of the proportional and integral terms in ACQ.
REQ-003 Parameter KP_SHIFT_TRK, 2; KI_SHIFT_TRK, 5: the same shifts in TRACK. Every shift value SHALL be in 0..6.
REQ-004 Parameter LOCK_CNT, 32: number of consecutive small-error cycles that declares lock.
REQ-005 Port list:
- clk_fb, input, xbit, loop clock (same edge on which the TDC code updates).
- rstn, input, 1, synchronous active-low reset.
- en, input, 1, update enable.
- in, input, signed [3:0], TDC timing-error code.
- out, output, [9:0], DCO control code.
- locked, output, 1, high in TRACK.

Function
REQ-006 Number format: F = 6 fractional bits; integ is unsigned Q10.6 (16 bits).
REQ-007 Per-cycle terms: p_term = (in <<< 6) >>> KP_SHIFT and i_term = (in <<< 6) >>> KI_SHIFT; both arithmetic and signed, using the shifts of the current state.
REQ-008 On each posedge clk_fb with en=1, integ SHALL take sat(integ + i_term) clamped to [0, 65535].
REQ-009 On the same edge, out SHALL take sat((integ_new + p_term) >>> 6) clamped to [0, 1023]. Latency is one cycle from in to out.
REQ-010 With en=0, integ, out, state and counters SHALL all hold.
REQ-011 FSM states are ACQ and TRACK; the state after reset is ACQ.
REQ-012 ACQ -> TRACK when |in|<=1 for LOCK_CNT consecutive enabled cycles.
- Any enabled cycle with |in|>1 clears the counter.
- The counter saturates at LOCK_CNT.
REQ-013 TRACK -> ACQ when |in|>=6 on 2 consecutive enabled cycles; the small-error counter clears on this transition.
REQ-014 New gains take effect on the cycle after a state transition. The edge that causes the transition uses the old gains.
REQ-015 locked SHALL be registered and equal to (state==TRACK).
REQ-016 in = -8 SHALL be handled as a legal input: no overflow of intermediates, with at least 18-bit signed sums.

Reset
REQ-017 Reset takes effect with rstn=0 at posedge clk_fb, regardless of en.
REQ-018 Values after reset:
- integ = INIT_CODE<<6
- out = INIT_CODE
- state = ACQ, locked = 0
- all counters 0
- DSM accumulator 0
REQ-019 Reset asserted mid-operation SHALL discard all state within that same edge.

Configuration
REQ-020 With DLF_DSM_EN defined, out SHALL be dithered by a first-order sigma-delta modulator:
- a 6-bit accumulator adds the fractional bits of (integ_new + p_term) each enabled cycle;
- the carry is added to the integer part;
- the result is then saturated to [0, 1023].
REQ-021 Without DLF_DSM_EN, the fractional bits SHALL be truncated as in REQ-009 and no accumulator SHALL exist.

Structure
REQ-022 Package dlf_pkg SHALL hold:
- the state enum dlf_state_t (ACQ, TRACK);
- the constants DLF_FRAC=6, DLF_OUT_W=10, DLF_INT_W=16;
- a saturation helper function.
REQ-023 The sub-module dlf_lock_fsm SHALL contain the state register, the two counters, the locked output and the gain-select output. The datapath stays in dlf_pi.

Verification
REQ-024 Reset, then in=+1 constant with en=1, defaults, no DSM:
- out = 513 after edge 1;
- out = 514 after edge 4;
- locked stays 0.
REQ-025 in=0 for 32 cycles, then edge 33 -> locked=1 and out held at 512; a following in=+1 uses i_term=2 and p_term=16.
REQ-026 Locked, then in=+7 on two edges -> locked=0 after the second edge. A single in=+7 followed by in=0 -> locked stays 1.
REQ-027 in=+7 held -> out and integ clamp at 1023 and 65535 with no wrap. in=-8 held -> out clamps at 0.
REQ-028 en=0 for 10 cycles with in=+7 -> out, integ and the lock counter are unchanged. rstn=0 mid-run -> out=512 and locked=0 on that edge.
REQ-029 DLF_DSM_EN defined, integ frozen at fraction 0.5 (in=0, TRACK, integ=512.5 preloaded via ACQ sequence) -> out alternates 512/513, mean 512.5 over 64 cycles.
